// File: rtl/rv32i_pkg.sv
// Shared rv32i constants for the load/store unit: widths, funct3 codes, LSU states.
// The ACC1 state exists only when LSU_MISALIGNED_EN is defined.
package rv32i_pkg;

    localparam int XLEN        = 32;
    localparam int WORD_ADDR_W = XLEN - 2;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACC0 = 2'd1,
        ST_RESP = 2'd2
`ifdef LSU_MISALIGNED_EN
        ,
        ST_ACC1 = 2'd3
`endif
    } lsu_state_e;

    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Request/response and data-RAM signal bundle between execute, the LSU and the RAM.
interface lsu_if;
    import rv32i_pkg::*;

    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [2:0]             req_funct3;
    logic [XLEN-1:0]        req_addr;
    logic [XLEN-1:0]        req_wdata;

    logic                   resp_valid;
    logic [XLEN-1:0]        resp_rdata;
    logic                   resp_misalign;
    logic                   resp_illegal;

    logic [WORD_ADDR_W-1:0] mem_addr;
    logic                   mem_we;
    logic [XLEN-1:0]        mem_wdata;
    logic [3:0]             mem_byte_en;
    logic [XLEN-1:0]        mem_rdata;

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_misalign, resp_illegal,
        output mem_addr, mem_we, mem_wdata, mem_byte_en
    );

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_misalign, resp_illegal,
        input  mem_addr, mem_we, mem_wdata, mem_byte_en
    );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables/data positioned over two words,
// load data extracted from a {w1,w0} pair and sign/zero-extended.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] w0_i,
    input  logic [31:0] w1_i,
    output logic [3:0]  be_lo_o,
    output logic [3:0]  be_hi_o,
    output logic [31:0] wdata_lo_o,
    output logic [31:0] wdata_hi_o,
    output logic [31:0] rdata_o
);

    logic [3:0]  mask;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide;
    logic [31:0] rd_sh;

    always_comb begin
        case (funct3_i[1:0])
            2'b00:   mask = 4'b0001;
            2'b01:   mask = 4'b0011;
            default: mask = 4'b1111;
        endcase
        // Lanes shifted past byte 3 land in the following word.
        be_wide = {4'b0000, mask} << off_i;
        wd_wide = {32'b0, wdata_i} << {off_i, 3'b000};
        rd_sh   = 32'({w1_i, w0_i} >> {off_i, 3'b000});

        case (funct3_i)
            F3_B:    rdata_o = {{24{rd_sh[7]}}, rd_sh[7:0]};
            F3_H:    rdata_o = {{16{rd_sh[15]}}, rd_sh[15:0]};
            F3_BU:   rdata_o = {24'b0, rd_sh[7:0]};
            F3_HU:   rdata_o = {16'b0, rd_sh[15:0]};
            default: rdata_o = rd_sh;
        endcase
    end

    assign be_lo_o    = be_wide[3:0];
    assign be_hi_o    = be_wide[7:4];
    assign wdata_lo_o = wd_wide[31:0];
    assign wdata_hi_o = wd_wide[63:32];

endmodule

// File: rtl/lsu.sv
// rv32i load/store unit: one access in flight, IDLE -> ACC0 -> [ACC1] -> RESP.
// Define LSU_MISALIGNED_EN to split word-crossing accesses instead of faulting them.
module lsu
    import rv32i_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        misalign_q;
    logic        illegal_q;

    logic        accept;
    logic        illegal_in;
    logic        misalign_in;
    logic        is_half;
    logic        is_word;
    logic [1:0]  off_in;
    logic        in_acc1;
    logic        store_acc;
    logic [3:0]  be_lo, be_hi;
    logic [31:0] wd_lo, wd_hi, ld_data, w0, w1;

    assign accept     = bus.req_valid && (state_q == ST_IDLE);
    assign off_in     = bus.req_addr[1:0];
    assign is_half    = (bus.req_funct3[1:0] == 2'b01);
    assign is_word    = (bus.req_funct3[1:0] == 2'b10);
    assign illegal_in = !f3_legal(bus.req_we, bus.req_funct3);

`ifdef LSU_MISALIGNED_EN
    logic        split_q;
    logic        split_in;
    logic [31:0] w0_q;

    assign misalign_in = 1'b0;
    assign split_in    = !illegal_in && ((is_half && off_in == 2'd3) || (is_word && off_in != 2'd0));
    assign in_acc1     = (state_q == ST_ACC1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            split_q <= 1'b0;
            w0_q    <= '0;
        end else begin
            if (accept) split_q <= split_in;
            if (state_q == ST_ACC1) w0_q <= bus.mem_rdata;
        end
    end
`else
    assign misalign_in = !illegal_in && ((is_half && off_in[0]) || (is_word && off_in != 2'd0));
    assign in_acc1     = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            f3_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            misalign_q <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                we_q       <= bus.req_we;
                f3_q       <= bus.req_funct3;
                addr_q     <= bus.req_addr;
                wdata_q    <= bus.req_wdata;
                misalign_q <= misalign_in;
                illegal_q  <= illegal_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = (illegal_in || misalign_in) ? ST_RESP : ST_ACC0;
`ifdef LSU_MISALIGNED_EN
            ST_ACC0: state_d = split_q ? ST_ACC1 : ST_RESP;
            ST_ACC1: state_d = ST_RESP;
`else
            ST_ACC0: state_d = ST_RESP;
`endif
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Split loads: first word was captured during ACC1, second arrives in RESP.
    always_comb begin
        w0 = bus.mem_rdata;
        w1 = '0;
`ifdef LSU_MISALIGNED_EN
        if (split_q) begin
            w0 = w0_q;
            w1 = bus.mem_rdata;
        end
`endif
    end

    lsu_align u_align (
        .funct3_i   (f3_q),
        .off_i      (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .w0_i       (w0),
        .w1_i       (w1),
        .be_lo_o    (be_lo),
        .be_hi_o    (be_hi),
        .wdata_lo_o (wd_lo),
        .wdata_hi_o (wd_hi),
        .rdata_o    (ld_data)
    );

    assign store_acc = we_q && ((state_q == ST_ACC0) || in_acc1);

    assign bus.req_ready     = (state_q == ST_IDLE);
    assign bus.mem_addr      = addr_q[31:2] + {29'b0, in_acc1};
    assign bus.mem_we        = store_acc;
    assign bus.mem_byte_en   = store_acc ? (in_acc1 ? be_hi : be_lo) : 4'b0000;
    assign bus.mem_wdata     = store_acc ? (in_acc1 ? wd_hi : wd_lo) : '0;

    assign bus.resp_valid    = (state_q == ST_RESP);
    assign bus.resp_misalign = bus.resp_valid && misalign_q;
    assign bus.resp_illegal  = bus.resp_valid && illegal_q;
    assign bus.resp_rdata    = (bus.resp_valid && !we_q && !misalign_q && !illegal_q) ? ld_data : '0;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed vector table, reset-mid-access sequence and random traffic
// checked against a byte-addressed memory model.
module tb_lsu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_if u_if();

    lsu dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    // 64-word RAM with registered read, aliased on the low address bits.
    logic [31:0] ram [64] = '{default: 32'h0};
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (u_if.mem_we && u_if.mem_byte_en[i])
                ram[u_if.mem_addr[5:0]][8*i +: 8] <= u_if.mem_wdata[8*i +: 8];
        end
        u_if.mem_rdata <= ram[u_if.mem_addr[5:0]];
    end

    // Reference: byte array matching the RAM aliasing (256 bytes).
    logic [7:0] mb [256] = '{default: 8'h0};

    int n_tests = 0;
    int n_fail  = 0;
    int n_txn   = 0;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        mis;
        logic        ill;
        int          lat;
    } vec_t;

    localparam int NV = 16;
    vec_t tbl [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic int szof(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] be);
        logic [31:0] m = '0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, output logic [31:0] got_rd,
                           output logic got_mis, output logic got_ill, output int got_lat);
        int          sz;
        logic        e_ill, e_mis, fault;
        int          nacc, e_lat;
        logic [3:0]  ebe [2];
        logic [31:0] ewd [2];
        logic [31:0] e_rd;
        logic [29:0] e_wa;
        logic        seen;

        sz    = szof(f3);
        e_ill = we ? !(f3 inside {3'b000, 3'b001, 3'b010})
                   : !(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
`ifdef LSU_MISALIGNED_EN
        e_mis = 1'b0;
`else
        e_mis = !e_ill && ((sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'd0));
`endif
        fault = e_ill || e_mis;

        ebe[0] = '0; ebe[1] = '0; ewd[0] = '0; ewd[1] = '0;
        nacc = 1;
        e_rd = '0;
        for (int j = 0; j < sz; j++) begin
            logic [31:0] ba;
            int wi;
            ba = addr + 32'(j);
            wi = (ba[31:2] != addr[31:2]) ? 1 : 0;
            if (wi + 1 > nacc) nacc = wi + 1;
            if (we) begin
                ebe[wi][ba[1:0]] = 1'b1;
                ewd[wi][8*ba[1:0] +: 8] = wd[8*j +: 8];
            end
            e_rd = e_rd | (32'(mb[ba[7:0]]) << (8 * j));
        end
        if (!f3[2] && sz == 1) e_rd = {{24{e_rd[7]}}, e_rd[7:0]};
        if (!f3[2] && sz == 2) e_rd = {{16{e_rd[15]}}, e_rd[15:0]};
        if (we || fault) e_rd = '0;
        e_lat = fault ? 1 : nacc + 1;

        @(negedge clk);
        chk("ready_idle", 32'(u_if.req_ready), 32'd1);
        u_if.req_valid  = 1'b1;
        u_if.req_we     = we;
        u_if.req_funct3 = f3;
        u_if.req_addr   = addr;
        u_if.req_wdata  = wd;
        @(posedge clk);
        #1 u_if.req_valid = 1'b0;

        seen = 1'b0; got_lat = 0; got_rd = '0; got_mis = 1'b0; got_ill = 1'b0;
        for (int n = 1; n <= 6 && !seen; n++) begin
            @(negedge clk);
            if (!fault && n <= nacc) begin
                e_wa = addr[31:2] + 30'(n - 1);
                chk("mem_addr", 32'(u_if.mem_addr), 32'(e_wa));
                chk("mem_we", 32'(u_if.mem_we), 32'(we));
                chk("byte_en", 32'(u_if.mem_byte_en), 32'(ebe[n-1]));
                if (we) chk("wdata", u_if.mem_wdata & lanes(ebe[n-1]), ewd[n-1]);
                chk("ready_busy", 32'(u_if.req_ready), 32'd0);
            end else begin
                chk("no_write", {27'b0, u_if.mem_we, u_if.mem_byte_en}, 32'd0);
            end
            if (u_if.resp_valid) begin
                seen    = 1'b1;
                got_lat = n;
                got_rd  = u_if.resp_rdata;
                got_mis = u_if.resp_misalign;
                got_ill = u_if.resp_illegal;
            end
        end
        if (!seen) chk("resp_timeout", 32'd0, 32'd1);
        chk("latency", 32'(got_lat), 32'(e_lat));
        chk("resp_rdata", got_rd, e_rd);
        chk("resp_misalign", 32'(got_mis), 32'(e_mis));
        chk("resp_illegal", 32'(got_ill), 32'(e_ill));
        @(negedge clk);
        chk("resp_pulse", 32'(u_if.resp_valid), 32'd0);

        if (we && !fault) begin
            for (int j = 0; j < sz; j++) begin
                logic [31:0] ba;
                ba = addr + 32'(j);
                mb[ba[7:0]] = wd[8*j +: 8];
            end
        end
        n_txn++;
        $display("[TB] txn %0d we=%0d f3=%0d addr=%08h wd=%08h rd=%08h mis=%0d ill=%0d lat=%0d",
                 n_txn, we, f3, addr, wd, got_rd, got_mis, got_ill, got_lat);
    endtask

    logic [31:0] rd;
    logic        mis, ill;
    int          lat;

    initial begin
        tbl[0]  = '{1'b1, 3'b010, 32'h0001C000, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, 2};
        tbl[1]  = '{1'b0, 3'b010, 32'h0001C000, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 2};
        tbl[2]  = '{1'b1, 3'b001, 32'h0001C000, 32'h0000C0DE, 32'h00000000, 1'b0, 1'b0, 2};
        tbl[3]  = '{1'b0, 3'b010, 32'h0001C000, 32'h0,        32'hDEADC0DE, 1'b0, 1'b0, 2};
        tbl[4]  = '{1'b0, 3'b000, 32'h0001C003, 32'h0,        32'hFFFFFFDE, 1'b0, 1'b0, 2};
        tbl[5]  = '{1'b0, 3'b100, 32'h0001C003, 32'h0,        32'h000000DE, 1'b0, 1'b0, 2};
        tbl[6]  = '{1'b0, 3'b001, 32'h0001C002, 32'h0,        32'hFFFFDEAD, 1'b0, 1'b0, 2};
        tbl[7]  = '{1'b0, 3'b101, 32'h0001C002, 32'h0,        32'h0000DEAD, 1'b0, 1'b0, 2};
        tbl[8]  = '{1'b1, 3'b010, 32'h0001C004, 32'h12345678, 32'h00000000, 1'b0, 1'b0, 2};
`ifdef LSU_MISALIGNED_EN
        tbl[9]  = '{1'b0, 3'b010, 32'h0001C002, 32'h0,        32'h5678DEAD, 1'b0, 1'b0, 3};
        tbl[13] = '{1'b0, 3'b001, 32'h0001C001, 32'h0,        32'hFFFFADC0, 1'b0, 1'b0, 2};
`else
        tbl[9]  = '{1'b0, 3'b010, 32'h0001C002, 32'h0,        32'h00000000, 1'b1, 1'b0, 1};
        tbl[13] = '{1'b0, 3'b001, 32'h0001C001, 32'h0,        32'h00000000, 1'b1, 1'b0, 1};
`endif
        tbl[10] = '{1'b1, 3'b011, 32'h0001C000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1};
        tbl[11] = '{1'b0, 3'b010, 32'h0001C000, 32'h0,        32'hDEADC0DE, 1'b0, 1'b0, 2};
        tbl[12] = '{1'b0, 3'b110, 32'h0001C000, 32'h0,        32'h00000000, 1'b0, 1'b1, 1};
        tbl[14] = '{1'b1, 3'b000, 32'h0001C001, 32'h000000A5, 32'h00000000, 1'b0, 1'b0, 2};
        tbl[15] = '{1'b0, 3'b010, 32'h0001C000, 32'h0,        32'hDEADA5DE, 1'b0, 1'b0, 2};

        u_if.req_valid  = 1'b0;
        u_if.req_we     = 1'b0;
        u_if.req_funct3 = 3'b000;
        u_if.req_addr   = '0;
        u_if.req_wdata  = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(u_if.req_ready), 32'd1);
        chk("rst_resp", {29'b0, u_if.resp_valid, u_if.resp_misalign, u_if.resp_illegal}, 32'd0);
        chk("rst_mem_ctl", {27'b0, u_if.mem_we, u_if.mem_byte_en}, 32'd0);
        chk("rst_rdata", u_if.resp_rdata, 32'd0);
        chk("rst_mem_addr", 32'(u_if.mem_addr), 32'd0);
        chk("rst_mem_wdata", u_if.mem_wdata, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_txn(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, rd, mis, ill, lat);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
            chk($sformatf("tbl%0d_flags", i), {30'b0, mis, ill}, {30'b0, tbl[i].mis, tbl[i].ill});
            chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
        end

        // Reset asserted while a SW sits in ACC0: nothing committed, no response.
        @(negedge clk);
        u_if.req_valid  = 1'b1;
        u_if.req_we     = 1'b1;
        u_if.req_funct3 = 3'b010;
        u_if.req_addr   = 32'h0001C000;
        u_if.req_wdata  = 32'h55AA55AA;
        @(posedge clk);
        #1 u_if.req_valid = 1'b0;
        chk("acc0_we", 32'(u_if.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_ready", 32'(u_if.req_ready), 32'd1);
        chk("midrst_ctl", {26'b0, u_if.resp_valid, u_if.mem_we, u_if.mem_byte_en}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("postrst_idle", {30'b0, u_if.resp_valid, u_if.req_ready}, 32'd1);
        end
        $display("[TB] txn reset-in-ACC0 SW addr=0001c000 wd=55aa55aa aborted");
        run_txn(1'b0, 3'b010, 32'h0001C000, 32'h0, rd, mis, ill, lat);
        chk("postrst_lw", rd, 32'hDEADA5DE);

        // Top-of-memory word access (splits across the address wrap when enabled).
        run_txn(1'b1, 3'b010, 32'hFFFFFFFE, 32'hA1B2C3D4, rd, mis, ill, lat);
        run_txn(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, rd, mis, ill, lat);
        run_txn(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, rd, mis, ill, lat);

        for (int i = 0; i < 200; i++) begin
            run_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom,
                    rd, mis, ill, lat);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
